// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Multi-channel input conditioner for raw switch/button levels. Each channel
// runs a two-flop synchronizer followed by a stability counter. The debounced
// level changes only after the synchronized input has disagreed with it for
// STABLE_CYCLES consecutive clock edges. Registered one-cycle rise/fall pulses
// accompany every level change.
//
// Parameters:
//   WIDTH          number of independent channels (lab top: bit0=p, bit1=B, bit2=A)
//   STABLE_CYCLES  consecutive disagreeing edges required for a level change (2..255)
//
// Ports:
//   clock       system clock, rising edge active
//   RST         asynchronous active-low reset, clears all state
//   raw_in      raw asynchronous switch levels
//   level_out   debounced, synchronized level per channel
//   rise_out    one-cycle pulse when level_out[i] goes 0->1
//   fall_out    one-cycle pulse when level_out[i] goes 1->0
//   any_change  OR of all rise_out/fall_out bits, same cycle as the pulses
// -----------------------------------------------------------------------------
module input_debouncer #(
    parameter int unsigned WIDTH         = 3,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             RST,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_out,
    output logic [WIDTH-1:0] fall_out,
    output logic             any_change
);

    // Counter only ever holds 0..STABLE_CYCLES-1, so ceil(log2) bits suffice.
    localparam int unsigned CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Synchronizer stages; sync1_q absorbs metastability from the raw pins.
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Debounced state and registered pulse outputs.
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             any_q, any_d;

    // Per-channel stability counters.
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // -------------------------------------------------------------------------
    // Next-state logic. Each channel is evaluated on its own; a channel only
    // moves its level when its counter has already seen STABLE_CYCLES-1
    // disagreeing edges and the current edge disagrees as well.
    // -------------------------------------------------------------------------
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == level_q[i]) begin
                // Any agreeing edge restarts the stability window.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
                rise_d[i]  = sync2_q[i];
                fall_d[i]  = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        any_d = |{rise_d, fall_d};
    end

    // -------------------------------------------------------------------------
    // State registers. Reset clears everything, including a pulse that would
    // otherwise have been issued on the coming edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge RST) begin
        if (!RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= any_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign level_out  = level_q;
    assign rise_out   = rise_q;
    assign fall_out   = fall_q;
    assign any_change = any_q;

endmodule

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
//
// Directed bench for input_debouncer with default parameters. Stimulus pushes
// the expected output event (edge number, level, rise, fall) into a queue when
// it changes raw_in; an independent monitor pops and compares whenever the DUT
// shows any activity on rise_out/fall_out/any_change.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

    localparam int unsigned WIDTH = 3;

    logic             clock;
    logic             RST;
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] level_out;
    logic [WIDTH-1:0] rise_out;
    logic [WIDTH-1:0] fall_out;
    logic             any_change;

    input_debouncer #(
        .WIDTH        (WIDTH),
        .STABLE_CYCLES(4)
    ) dut (
        .clock     (clock),
        .RST       (RST),
        .raw_in    (raw_in),
        .level_out (level_out),
        .rise_out  (rise_out),
        .fall_out  (fall_out),
        .any_change(any_change)
    );

    typedef struct {
        int         cyc;
        logic [2:0] lvl;
        logic [2:0] rise;
        logic [2:0] fall;
    } event_t;

    event_t exp_q[$];
    int     cyc     = 0;
    int     n_total = 0;
    int     n_pass  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Rising-edge counter; read at negedges only.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    endtask

    // Expect an output event observed at the negedge when cyc == at.
    task automatic push(input int at, input logic [2:0] lvl, input logic [2:0] r,
                        input logic [2:0] f);
        event_t e;
        e.cyc  = at;
        e.lvl  = lvl;
        e.rise = r;
        e.fall = f;
        exp_q.push_back(e);
    endtask

    // Monitor: every visible pulse must match the oldest expected event.
    always @(negedge clock) begin
        if (any_change || (|rise_out) || (|fall_out)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {32'(cyc), 1'b0, level_out, rise_out, fall_out,
                      any_change}, 64'h0);
            end else begin
                event_t e;
                e = exp_q.pop_front();
                check("event", {32'(cyc), 1'b0, level_out, rise_out, fall_out, any_change},
                      {32'(e.cyc), 1'b0, e.lvl, e.rise, e.fall, 1'b1});
            end
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Change raw_in at a negedge; the following posedge captures it (edge k)
    // and the pulse is visible after edge k+5, i.e. six edges from now.
    task automatic drive(input logic [2:0] v, input logic [2:0] lvl, input logic [2:0] r,
                         input logic [2:0] f);
        raw_in = v;
        push(cyc + 6, lvl, r, f);
    endtask

    initial begin
        RST    = 1'b0;
        raw_in = 3'b111;

        // 1. Reset with inputs already high.
        wait_neg(3);
        check("reset_outputs", {level_out, rise_out, fall_out, any_change}, 64'h0);
        RST = 1'b1;
        push(cyc + 6, 3'b111, 3'b111, 3'b000);
        wait_neg(10);
        check("level_after_reset", level_out, 3'b111);

        drive(3'b000, 3'b000, 3'b000, 3'b111);
        wait_neg(10);
        check("level_all_low", level_out, 3'b000);

        // 2. Clean step on channel 0.
        drive(3'b001, 3'b001, 3'b001, 3'b000);
        wait_neg(10);
        check("level_step_up", level_out, 3'b001);
        drive(3'b000, 3'b000, 3'b000, 3'b001);
        wait_neg(10);
        check("level_step_down", level_out, 3'b000);

        // 3. Bounce on channel 1, then hold high.
        raw_in = 3'b010; wait_neg(1);
        raw_in = 3'b000; wait_neg(1);
        raw_in = 3'b010; wait_neg(1);
        raw_in = 3'b000; wait_neg(1);
        drive(3'b010, 3'b010, 3'b010, 3'b000);
        for (int i = 0; i < 5; i++) begin
            check("bounce_hold_low", level_out[1], 1'b0);
            wait_neg(1);
        end
        wait_neg(5);
        check("level_bounce", level_out, 3'b010);
        drive(3'b000, 3'b000, 3'b000, 3'b010);
        wait_neg(10);

        // 4. Glitch of three cycles on channel 2 must be rejected.
        raw_in = 3'b100;
        wait_neg(3);
        raw_in = 3'b000;
        for (int i = 0; i < 10; i++) begin
            check("glitch_level", level_out[2], 1'b0);
            wait_neg(1);
        end

        // 5. Two channels change together.
        drive(3'b101, 3'b101, 3'b101, 3'b000);
        wait_neg(10);
        check("level_simul", level_out, 3'b101);
        drive(3'b000, 3'b000, 3'b000, 3'b101);
        wait_neg(10);

        // 6. Reset while channel 0 is mid-count (cnt[0]==2 four edges in).
        raw_in = 3'b001;
        wait_neg(4);
        #1 RST = 1'b0;
        #1 check("midcount_reset_outputs", {level_out, rise_out, fall_out, any_change}, 64'h0);
        #1 RST = 1'b1;
        // First edge after release recaptures the high input from scratch.
        push(cyc + 6, 3'b001, 3'b001, 3'b000);
        wait_neg(3);
        check("midcount_no_early_level", level_out, 3'b000);
        wait_neg(7);
        check("level_after_midcount", level_out, 3'b001);
        drive(3'b000, 3'b000, 3'b000, 3'b001);
        wait_neg(10);

        check("pending_events", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Multi-channel input conditioner that sits directly upstream of the lab state machines. It takes raw, asynchronous, bouncing switch/button levels (the A, B and p inputs of the sequence-detector and counter FSMs) and produces clean, clock-synchronous levels plus single-cycle rising/falling-edge pulses. Each channel runs a 2-flop synchronizer followed by a stability counter. The block's outputs drive the FSM inputs directly.

## Interface

Parameters:
- WIDTH, default 3: number of independent input channels. Bit 0 is p, bit 1 is B, bit 2 is A in the lab top level.
- STABLE_CYCLES, default 4: consecutive clock cycles a synchronized input must differ from the current debounced level before that level changes. Legal range is 2..255.

Ports:
- clock, input, 1: single system clock; all state updates on the rising edge.
- RST, input, 1: asynchronous, active-low reset. RST=0 clears all state immediately, independent of clock.
- raw_in, input, WIDTH: raw asynchronous switch levels.
- level_out, output, WIDTH: debounced, synchronized level per channel.
- rise_out, output, WIDTH: one-cycle pulse when level_out[i] goes 0→1.
- fall_out, output, WIDTH: one-cycle pulse when level_out[i] goes 1→0.
- any_change, output, 1: OR of all bits of rise_out and fall_out, registered with them (same cycle).

## Operation

- Each channel i has the following state:
  - sync1[i], sync2[i]: synchronizer flops.
  - level[i]: drives level_out[i].
  - cnt[i]: width ceil(log2(STABLE_CYCLES)).
  - rise[i] and fall[i]: registered pulse outputs.
- Every rising clock edge:
  - sync1 <= raw_in; sync2 <= sync1.
  - If sync2[i] == level[i]: cnt[i] <= 0.
  - Else if cnt[i] == STABLE_CYCLES-1: level[i] <= sync2[i] and cnt[i] <= 0. rise[i] <= sync2[i]; fall[i] <= ~sync2[i].
  - Else: cnt[i] <= cnt[i]+1.
  - rise[i] and fall[i] are 0 on every edge that does not update level[i].
- A run of mismatches shorter than STABLE_CYCLES is a glitch. Any single cycle of sync2 == level restarts the count from 0, and level never changes.
- Channels are fully independent. Simultaneous changes on several channels are each processed on their own counters. any_change is asserted once for that cycle.
- cnt never exceeds STABLE_CYCLES-1, so there is no wrap-around.
- rise[i] and fall[i] are never both 1.

## Timing

- Reset values, all zero: sync1, sync2, level_out, cnt, rise_out, fall_out, any_change.
- Latency: a raw change captured at edge k has these effects:
  - sync2 takes the new value at edge k+1.
  - level_out changes at edge k+1+STABLE_CYCLES, which is STABLE_CYCLES+2 edges including edge k. With the default this is 6 edges.
  - rise_out/fall_out are high for exactly the one cycle following that edge.
- Minimum pulse width accepted: a raw level must be held for STABLE_CYCLES consecutive sampled edges at sync2.
- Reset mid-count: RST=0 clears cnt and level immediately. After RST returns to 1, a raw input that is already 1 behaves as a fresh 0→1 change and produces a rise pulse after the full latency.
- Reset asserted in the same cycle a pulse would be issued: reset wins, and no pulse appears.
- Raw inputs need no setup/hold relationship to clock. Metastability is absorbed by sync1.

## Test plan

All scenarios use the default parameters (STABLE_CYCLES=4, WIDTH=3).

1. Reset: hold RST=0 with raw_in=3'b111 → all outputs 0. Release RST at edge 0 → level_out=3'b111 after edge 6, with rise_out=3'b111 and any_change=1 for exactly one cycle.
2. Clean step: raw_in[0] 0→1 captured at edge k → level_out[0]=1 after edge k+5, rise_out[0]=1 for exactly one cycle. Then 1→0 produces the same latency with a one-cycle fall_out[0].
3. Bounce: raw_in[1] toggles 1,0,1,0,1 every cycle, then holds 1 → no change during the toggling. level_out[1] rises 6 edges after the final hold begins, and exactly one rise pulse is produced.
4. Glitch rejection: raw_in[2] high for 3 cycles, then low → level_out[2] stays 0, rise_out and any_change stay 0 throughout.
5. Simultaneous channels: raw_in 3'b000→3'b101 in one cycle → level_out=3'b101 on the same edge, rise_out=3'b101 and any_change=1 for a single cycle.
6. Reset mid-count: raw_in[0]=1 and RST pulsed low while cnt[0]=2 → no pulse. After release, the full 6-edge latency applies from the first edge after release.
